// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port, shared memory bus and status for mem_arbiter.
// Handshake: a requester raises *_req with stable operands and holds them until its *_valid pulse;
// the arbiter holds mem_req with stable mem_addr/mem_we/mem_wdata until a cycle with mem_ready=1.
interface mem_arbiter_if;
  import arb_pkg::*;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        stall_f;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall_m;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        err;
  arb_state_t  fsm_state;

  // master: the arbiter itself
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, stall_f, d_rdata, d_valid, stall_m,
    output mem_req, mem_we, mem_addr, mem_wdata, err, fsm_state
  );

  // slave: requesters and the memory seen from outside the arbiter
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, stall_f, d_rdata, d_valid, stall_m,
    input  mem_req, mem_we, mem_addr, mem_wdata, err, fsm_state
  );

endinterface

// File: rtl/arb_watchdog.sv
// Counts consecutive busy cycles without mem_ready; flags expiry and keeps a sticky error bit.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ready,
  output logic expired,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Expires on the TIMEOUT_CYCLES-th busy cycle that still has no ready.
  assign expired = busy & ~ready & (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (!busy || ready || expired) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
      if (expired) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store ports; data has priority over fetch.
// Define ARB_TIMEOUT_EN to add the mem_ready watchdog (arb_watchdog) and the sticky err flag.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t state;
  arb_state_t state_next;
  logic       grant_d;
  logic       grant_f;
  logic       done;
  logic       timeout;
  logic       busy;

  assign busy = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  logic wd_err;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy),
    .ready  (bus.mem_ready),
    .expired(timeout),
    .err    (wd_err)
  );

  assign bus.err = wd_err;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  // A port whose valid is high this cycle is still finishing its handshake, so it is not eligible.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.d_req && !bus.d_valid) begin
          state_next = DATA;
          grant_d    = 1'b1;
        end else if (bus.if_req && !bus.if_valid) begin
          state_next = FETCH;
          grant_f    = 1'b1;
        end
      end
      FETCH, DATA: begin
        if (bus.mem_ready || timeout) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_valid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_valid   <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      if (grant_d) begin
        bus.mem_addr  <= bus.d_addr;
        bus.mem_we    <= bus.d_we;
        bus.mem_wdata <= bus.d_wdata;
      end else if (grant_f) begin
        bus.mem_addr <= bus.if_addr;
        bus.mem_we   <= 1'b0;
      end
      if (done) begin
        if (state == FETCH) begin
          bus.if_valid <= 1'b1;
          bus.if_rdata <= timeout ? 32'h0 : bus.mem_rdata;
        end else begin
          bus.d_valid <= 1'b1;
          // A completed store leaves the last load result in place.
          if (timeout) begin
            bus.d_rdata <= 32'h0;
          end else if (!bus.mem_we) begin
            bus.d_rdata <= bus.mem_rdata;
          end
        end
      end
    end
  end

  assign bus.mem_req   = busy;
  assign bus.stall_f   = bus.if_req & ~bus.if_valid;
  assign bus.stall_m   = bus.d_req & ~bus.d_valid;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized concurrent traffic
// against a transaction-level memory model and a randomly delayed memory responder.
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int TO = 16;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if bus();

  mem_arbiter #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_time_limit reached before summary");
    $fatal(1, "simulation time limit");
  end

  // ---------------- memory contents ----------------
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  logic [31:0] resp_mem [logic [31:0]];  // what the responder memory holds
  logic [31:0] ref_mem  [logic [31:0]];  // what the bench expects memory to hold

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : rom_fn(a);
  endfunction

  // ---------------- memory responder ----------------
  int lat_min = 0;
  int lat_max = 0;
  bit resp_en = 1'b1;
  int wait_cnt = 0;
  int cur_lat = -1;

  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom();
    if (rst || !bus.mem_req) begin
      wait_cnt = 0;
      cur_lat  = -1;
    end else if (resp_en) begin
      if (cur_lat < 0) cur_lat = $urandom_range(lat_max, lat_min);
      if (wait_cnt >= cur_lat) begin
        bus.mem_ready = 1'b1;
        if (bus.mem_we) resp_mem[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = resp_mem.exists(bus.mem_addr) ? resp_mem[bus.mem_addr] : rom_fn(bus.mem_addr);
        wait_cnt = 0;
        cur_lat  = -1;
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- driver helpers ----------------
  logic [31:0] last_load;  // expected d_rdata

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.err, bus.stall_f, bus.stall_m} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.err, bus.stall_f, bus.stall_m});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h %h %h %h exp=0", bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
    end
    checks++;
    if (bus.fsm_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", bus.fsm_state, IDLE);
    end
    tick();
    rst = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got mem_req=%b exp=0", bus.mem_req);
    end
    tick();
  endtask

  task automatic test_single_fetch();
    lat_min = 0; lat_max = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    @(negedge clk);  // cycle 0
    checks++;
    if (bus.stall_f !== 1'b1 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c0 got stall_f=%b mem_req=%b exp 1 0", bus.stall_f, bus.mem_req);
    end
    tick();
    @(negedge clk);  // cycle 1
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_f, bus.if_valid} !== {1'b1, 1'b0, 32'h4, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL fetch_c1 got req=%b we=%b addr=%h stall_f=%b valid=%b exp 1 0 00000004 1 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_f, bus.if_valid);
    end
    tick();
    @(negedge clk);  // cycle 2
    checks++;
    if ({bus.if_valid, bus.if_rdata, bus.stall_f} !== {1'b1, 32'h0050_0093, 1'b0}) begin
      failures++;
      $display("FAIL fetch_c2 got valid=%b rdata=%h stall_f=%b exp 1 00500093 0",
               bus.if_valid, bus.if_rdata, bus.stall_f);
    end
    tick();
    bus.if_req = 1'b0;
    @(negedge clk);  // cycle 3: no regrant from the valid cycle
    checks++;
    if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c3_no_regrant got req=%b valid=%b exp 0 0", bus.mem_req, bus.if_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int vc[2];
    int nv = 0;
    int busy = 0;
    int overlap = 0;
    bit sv;
    lat_min = 0; lat_max = 0;
    vc[0] = -1; vc[1] = -1;
    bus.if_addr = 32'h0; bus.if_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sv = bus.if_valid;
      if (bus.mem_req) busy++;
      if (bus.mem_req && bus.if_valid) overlap++;
      if (sv && nv < 2) begin
        vc[nv] = c;
        checks++;
        if (bus.if_rdata !== ref_read(nv == 0 ? 32'h0 : 32'h4)) begin
          failures++;
          $display("FAIL b2b_rdata%0d got=%h exp=%h", nv, bus.if_rdata, ref_read(nv == 0 ? 32'h0 : 32'h4));
        end
        nv++;
      end
      tick();
      if (sv) begin
        if (nv == 1) bus.if_addr = 32'h4;
        else bus.if_req = 1'b0;
      end
    end
    checks++;
    if (vc[0] !== 2 || vc[1] !== 5) begin
      failures++;
      $display("FAIL b2b_valid_cycles got=%0d,%0d exp=2,5", vc[0], vc[1]);
    end
    checks++;
    if (busy !== 2 || overlap !== 0) begin
      failures++;
      $display("FAIL b2b_ownership got busy=%0d overlap=%0d exp 2 0", busy, overlap);
    end
  endtask

  task automatic test_priority();
    logic [31:0] exp_d;
    lat_min = 0; lat_max = 0;
    exp_d = ref_read(32'h100);
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    tick();
    @(negedge clk);  // cycle 1: data owns memory
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_f, bus.stall_m} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL prio_data_first got req=%b we=%b addr=%h sf=%b sm=%b exp 1 0 00000100 1 1",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_f, bus.stall_m);
    end
    tick();
    @(negedge clk);  // cycle 2
    checks++;
    if ({bus.d_valid, bus.if_valid, bus.d_rdata} !== {1'b1, 1'b0, exp_d}) begin
      failures++;
      $display("FAIL prio_d_valid got dv=%b iv=%b d_rdata=%h exp 1 0 %h", bus.d_valid, bus.if_valid, bus.d_rdata, exp_d);
    end
    last_load = exp_d;
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);  // cycle 3: fetch granted in the data valid cycle
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.d_valid} !== {1'b1, 1'b0, 32'h8, 1'b0}) begin
      failures++;
      $display("FAIL prio_fetch_next got req=%b we=%b addr=%h dv=%b exp 1 0 00000008 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.d_valid);
    end
    tick();
    @(negedge clk);  // cycle 4: two cycles after d_valid
    checks++;
    if ({bus.if_valid, bus.if_rdata} !== {1'b1, ref_read(32'h8)}) begin
      failures++;
      $display("FAIL prio_if_valid got iv=%b rdata=%h exp 1 %h", bus.if_valid, bus.if_rdata, ref_read(32'h8));
    end
    tick();
    bus.if_req = 1'b0;
  endtask

  task automatic test_store();
    int busy = 0;
    int nv = 0;
    bit sv;
    lat_min = 2; lat_max = 2;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (bus.stall_m !== 1'b1) begin
          failures++;
          $display("FAIL store_stall_m got=%b exp=1", bus.stall_m);
        end
      end
      if (bus.mem_req) begin
        busy++;
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h200, 32'hDEAD_BEEF}) begin
          failures++;
          $display("FAIL store_bus c%0d got we=%b addr=%h wdata=%h exp 1 00000200 deadbeef",
                   c, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      sv = bus.d_valid;
      if (sv) begin
        nv++;
        checks++;
        if (bus.d_rdata !== last_load) begin
          failures++;
          $display("FAIL store_rdata_kept got=%h exp=%h", bus.d_rdata, last_load);
        end
      end
      tick();
      if (c == 1) begin  // mid-transaction operand changes must be ignored
        bus.d_addr = 32'h300; bus.d_wdata = 32'h0; bus.d_we = 1'b0;
      end
      if (sv) bus.d_req = 1'b0;
    end
    ref_mem[32'h200] = 32'hDEAD_BEEF;
    checks++;
    if (busy !== 3 || nv !== 1) begin
      failures++;
      $display("FAIL store_counts got busy=%0d valids=%0d exp 3 1", busy, nv);
    end
    bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    resp_en = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy got mem_req=%b exp=1", bus.mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req, bus.d_valid, bus.d_rdata} !== {1'b0, 1'b0, 32'h0} || bus.fsm_state !== IDLE) begin
      failures++;
      $display("FAIL rstmid_async got req=%b dv=%b d_rdata=%h state=%0d exp 0 0 0 %0d",
               bus.mem_req, bus.d_valid, bus.d_rdata, bus.fsm_state, IDLE);
    end
    tick();
    bus.d_req = 1'b0;
    tick();
    rst = 1'b0;
    last_load = 32'h0;
    resp_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0 || bus.d_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rstmid_after got bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_timeout();
    int vcyc = -1;
    logic [31:0] rd = '0;
    logic er = 1'b0;
    resp_en = 1'b0;
    lat_min = 0; lat_max = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.if_valid && vcyc < 0) begin
        vcyc = c; rd = bus.if_rdata; er = bus.err;
      end
      tick();
      if (vcyc == c) bus.if_req = 1'b0;
    end
`ifdef ARB_TIMEOUT_EN
    checks++;
    if (vcyc !== TO + 1 || rd !== 32'h0 || er !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse got cycle=%0d rdata=%h err=%b exp %0d 0 1", vcyc, rd, er, TO + 1);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got err=%b exp=1", bus.err);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_cleared got err=%b exp=0", bus.err);
    end
    tick();
    resp_en = 1'b1;
`else
    checks++;
    if (vcyc !== -1) begin
      failures++;
      $display("FAIL nowait_limit got valid_cycle=%0d exp none", vcyc);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.mem_req !== 1'b1 || bus.stall_f !== 1'b1) begin
      failures++;
      $display("FAIL nowait_state got err=%b req=%b stall_f=%b exp 0 1 1", bus.err, bus.mem_req, bus.stall_f);
    end
    tick();
    resp_en = 1'b1;
    vcyc = -1;
    for (int c = 0; c < 10 && vcyc < 0; c++) begin
      @(negedge clk);
      if (bus.if_valid) begin
        vcyc = c; rd = bus.if_rdata;
      end
      tick();
    end
    bus.if_req = 1'b0;
    checks++;
    if (vcyc < 0 || rd !== ref_read(32'h40)) begin
      failures++;
      $display("FAIL nowait_complete got cycle=%0d rdata=%h exp %h", vcyc, rd, ref_read(32'h40));
    end
`endif
  endtask

  task automatic test_random();
    lat_min = 0; lat_max = 3;
    fork
      begin : fetch_side
        logic [31:0] a;
        bit got;
        for (int n = 0; n < 20; n++) begin
          repeat ($urandom_range(3, 0)) tick();
          a = 32'h400 + ($urandom_range(255, 0) << 2);
          bus.if_addr = a; bus.if_req = 1'b1; got = 1'b0;
          for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (bus.if_valid) begin
              got = 1'b1;
              checks++;
              if (bus.if_rdata !== ref_read(a) || c < 2) begin
                failures++;
                $display("FAIL rand_fetch%0d got=%h at c%0d exp=%h at c>=2", n, bus.if_rdata, c, ref_read(a));
              end
            end else if (bus.stall_f !== 1'b1) begin
              failures++;
              $display("FAIL rand_stall_f%0d got=0 exp=1", n);
            end
            tick();
          end
          bus.if_req = 1'b0;
          if (!got) begin
            failures++;
            $display("FAIL rand_fetch_wait%0d no if_valid exp within 60 cycles", n);
          end
        end
      end
      begin : data_side
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        bit got;
        for (int n = 0; n < 20; n++) begin
          repeat ($urandom_range(3, 0)) tick();
          a  = 32'h1000_0000 + ($urandom_range(7, 0) << 2);
          we = 1'($urandom_range(1, 0));
          wd = $urandom();
          bus.d_addr = a; bus.d_we = we; bus.d_wdata = wd; bus.d_req = 1'b1; got = 1'b0;
          for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (bus.d_valid) begin
              got = 1'b1;
              checks++;
              if (we) begin
                if (bus.d_rdata !== last_load) begin
                  failures++;
                  $display("FAIL rand_store%0d d_rdata got=%h exp=%h", n, bus.d_rdata, last_load);
                end
                ref_mem[a] = wd;
              end else begin
                if (bus.d_rdata !== ref_read(a)) begin
                  failures++;
                  $display("FAIL rand_load%0d got=%h exp=%h", n, bus.d_rdata, ref_read(a));
                end
                last_load = ref_read(a);
              end
            end else if (bus.stall_m !== 1'b1) begin
              failures++;
              $display("FAIL rand_stall_m%0d got=0 exp=1", n);
            end
            tick();
          end
          bus.d_req = 1'b0;
          if (!got) begin
            failures++;
            $display("FAIL rand_data_wait%0d no d_valid exp within 60 cycles", n);
          end
        end
      end
    join
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resp_mem[32'h4] = 32'h0050_0093;
    ref_mem[32'h4]  = 32'h0050_0093;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_priority();
    test_store();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
